sr_flag_arbiter: RTL and testbench

Round-robin controller that lets several requesters share one bank of SR flip-flop flag cells. Each requester issues set/clear commands for a flag index through a valid/ready handshake. The arbiter serialises them into one-cycle S/R pulses toward the bank, so S and R are never both asserted on any cell. It also keeps a shadow copy of the bank state for readback, and sits between software/FSM requesters and the flag bank.

---
 rtl/sr_flag_arbiter.sv | 84 ++++++++
 tb/tb_sr_flag_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises per-requester set/clear commands into
// one-cycle S/R pulses toward an SR flag bank, with a shadow copy of the bank.
module sr_flag_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NFLAG = 8,
    parameter int unsigned IDW   = $clog2(NFLAG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_op,
    input  logic [NREQ*IDW-1:0]      req_idx,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clear_all,
    output logic [NFLAG-1:0]         flag_S,
    output logic [NFLAG-1:0]         flag_R,
    output logic [NFLAG-1:0]         flags,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned GW = $clog2(NREQ);

    logic [GW-1:0]    ptr;
    logic [GW-1:0]    nxt_ptr;
    logic             hit;
    logic             sel_op;
    logic [IDW-1:0]   sel_idx;
    logic [NFLAG-1:0] mask;
    int unsigned      cand;

    // First valid requester at or after ptr, wrapping; clear_all and rst block all grants.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        hit       = 1'b0;
        sel_op    = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        if (!rst && !clear_all) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = (32'(ptr) + k) % NREQ;
                if (!hit && req_valid[cand]) begin
                    hit             = 1'b1;
                    req_ready[cand] = 1'b1;
                    grant_id        = GW'(cand);
                    sel_op          = req_op[cand];
                    sel_idx         = req_idx[cand*IDW +: IDW];
                end
            end
        end
    end

    // One-hot decode of the granted index; indices >= NFLAG match nothing.
    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < NFLAG; k++) begin
            mask[k] = (sel_idx == IDW'(k));
        end
    end

    assign nxt_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);

    // Pulse registers, shadow and pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            flag_S <= '0;
            flag_R <= '0;
            flags  <= '0;
        end else begin
            flags  <= (flags | flag_S) & ~flag_R;
            flag_S <= '0;
            flag_R <= '0;
            if (clear_all) begin
                flag_R <= '1;
            end else if (hit) begin
                ptr    <= nxt_ptr;
                flag_S <= sel_op ? mask : '0;
                flag_R <= sel_op ? '0 : mask;
            end
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench: a queue-based reference model drives two arbiters
// (8 flags and 6 flags) with identical stimulus and checks grants, pulses, shadow.
module tb_sr_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_op;
    logic [11:0] req_idx;
    logic        clear_all;

    logic [3:0]  rdy8, rdy6;
    logic [1:0]  gid8, gid6;
    logic [7:0]  s8, r8, f8;
    logic [5:0]  s6, r6, f6;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) u8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_idx(req_idx), .req_ready(rdy8), .clear_all(clear_all),
        .flag_S(s8), .flag_R(r8), .flags(f8), .grant_id(gid8)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6)) u6 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_idx(req_idx), .req_ready(rdy6), .clear_all(clear_all),
        .flag_S(s6), .flag_R(r6), .flags(f6), .grant_id(gid6)
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] f;
    } pr_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;
    bit  t3_on = 1'b0;

    int  gq[$];
    pr_t pq8[$];
    pr_t pq6[$];
    int  t3_seen[$];

    // Reference model state
    int         ptr;
    bit         pv[4];
    logic       po[4];
    logic [2:0] pi[4];
    logic [7:0] sh8, sh6, cs8, cr8, cs6, cr6, ns8, nr8, ns6, nr6;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic post(input int r, input logic op, input logic [2:0] idx);
        pv[r] = 1'b1;
        po[r] = op;
        pi[r] = idx;
    endtask

    task automatic model_init();
        ptr = 0;
        for (int r = 0; r < 4; r++) pv[r] = 1'b0;
        sh8 = '0; sh6 = '0; cs8 = '0; cr8 = '0; cs6 = '0; cr6 = '0;
        ns8 = '0; nr8 = '0; ns6 = '0; nr6 = '0;
    endtask

    // Advance model one cycle, push expectations, drive inputs for this cycle.
    task automatic drive_cycle(input logic clr);
        pr_t p;
        sh8 = (sh8 | cs8) & ~cr8;
        sh6 = (sh6 | cs6) & ~cr6;
        cs8 = ns8; cr8 = nr8; cs6 = ns6; cr6 = nr6;
        if ((cs8 | cr8) != 0) begin
            p.s = cs8; p.r = cr8; p.f = sh8;
            pq8.push_back(p);
        end
        if ((cs6 | cr6) != 0) begin
            p.s = cs6; p.r = cr6; p.f = sh6;
            pq6.push_back(p);
        end
        for (int r = 0; r < 4; r++) begin
            req_valid[r]       = pv[r];
            req_op[r]          = po[r];
            req_idx[r*3 +: 3]  = pi[r];
        end
        clear_all = clr;
        ns8 = '0; nr8 = '0; ns6 = '0; nr6 = '0;
        if (clr) begin
            nr8 = 8'hFF;
            nr6 = 8'h3F;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (ptr + k) % 4;
                if (pv[i]) begin
                    gq.push_back(i);
                    ptr = (i + 1) % 4;
                    ns8[pi[i]] = po[i];
                    nr8[pi[i]] = ~po[i];
                    if (pi[i] < 6) begin
                        ns6[pi[i]] = po[i];
                        nr6[pi[i]] = ~po[i];
                    end
                    pv[i] = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic clr);
        @(posedge clk);
        #1;
        drive_cycle(clr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    // Monitor: pops expectations whenever a DUT presents a grant or a pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            int  id;
            pr_t p;
            check("sr_overlap8", 32'(s8 & r8), 32'd0);
            check("sr_overlap6", 32'(s6 & r6), 32'd0);
            if (rdy8 != 0) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", 32'(rdy8), 32'd0);
                end else begin
                    id = gq.pop_front();
                    check("ready8", 32'(rdy8), 32'd1 << id);
                    check("grant_id8", 32'(gid8), 32'(id));
                    check("ready6", 32'(rdy6), 32'd1 << id);
                    check("grant_id6", 32'(gid6), 32'(id));
                    if (t3_on) t3_seen.push_back(int'(gid8));
                end
            end
            if ((s8 | r8) != 0) begin
                if (pq8.size() == 0) begin
                    check("unexpected_pulse8", 32'(s8 | r8), 32'd0);
                end else begin
                    p = pq8.pop_front();
                    check("flag_S8", 32'(s8), 32'(p.s));
                    check("flag_R8", 32'(r8), 32'(p.r));
                    check("flags8", 32'(f8), 32'(p.f));
                end
            end
            if ((s6 | r6) != 0) begin
                if (pq6.size() == 0) begin
                    check("unexpected_pulse6", 32'(s6 | r6), 32'd0);
                end else begin
                    p = pq6.pop_front();
                    check("flag_S6", 32'({2'b00, s6}), 32'(p.s));
                    check("flag_R6", 32'({2'b00, r6}), 32'(p.r));
                    check("flags6", 32'({2'b00, f6}), 32'(p.f));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid = 4'hF;
        req_op = '0;
        req_idx = '0;
        clear_all = 1'b0;
        model_init();

        // Reset state, then a pulse killed asynchronously by rst
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(rdy8), 32'd0);
        check("reset_S", 32'(s8), 32'd0);
        check("reset_R", 32'(r8), 32'd0);
        check("reset_flags", 32'(f8), 32'd0);
        check("reset_gid", 32'(gid8), 32'd0);
        rst = 1'b0;
        req_valid = 4'b0001; req_op = 4'b0001; req_idx = 12'd3;
        @(negedge clk);
        check("t1_ready", 32'(rdy8), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        check("t1_pulse3", 32'(s8), 32'h08);
        @(posedge clk); #1;
        check("t1_flags3", 32'(f8), 32'h08);
        req_valid = 4'b0010; req_op = 4'b0010; req_idx = 12'(5 << 3);
        @(posedge clk); #1;
        req_valid = '0;
        check("t1_pulse5", 32'(s8), 32'h20);
        #2;
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("t1_kill_S", 32'(s8), 32'd0);
        check("t1_kill_R", 32'(r8), 32'd0);
        check("t1_kill_flags", 32'(f8), 32'd0);
        check("t1_kill_flags6", 32'(f6), 32'd0);
        check("t1_kill_ready", 32'(rdy8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_init();
        mon_en = 1'b1;

        // Fairness: all requesters kept valid for 8 cycles starting right after reset
        t3_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            for (int r = 0; r < 4; r++)
                if (!pv[r]) post(r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            drive_cycle(1'b0);
        end
        @(negedge clk); #1;
        t3_on = 1'b0;
        check("t3_count", 32'(t3_seen.size()), 32'd8);
        for (int i = 0; i < t3_seen.size(); i++)
            check("t3_order", 32'(t3_seen[i]), 32'(i % 4));
        idle(6);

        // Single set / clear on flag 5
        step(1'b1);
        idle(3);
        post(0, 1'b1, 3'd5);
        step(1'b0);
        idle(3);
        @(negedge clk);
        check("t2_set_flags", 32'(f8), 32'h20);
        post(0, 1'b0, 3'd5);
        step(1'b0);
        idle(3);
        @(negedge clk);
        check("t2_clr_flags", 32'(f8), 32'h00);

        // clear_all priority over a simultaneous request
        for (int k = 0; k < 8; k++) begin
            post(k % 4, 1'b1, 3'(k));
            step(1'b0);
        end
        idle(3);
        @(negedge clk);
        check("t4_all_set", 32'(f8), 32'hFF);
        post(2, 1'b1, 3'd1);
        step(1'b1);
        @(negedge clk);
        check("t4_blocked", 32'(rdy8), 32'd0);
        step(1'b0);
        @(negedge clk);
        check("t4_req2_granted", 32'(rdy8), 32'b0100);
        idle(3);
        @(negedge clk);
        check("t4_flags8", 32'(f8), 32'h02);
        check("t4_flags6", 32'(f6), 32'h02);

        // Same flag back-to-back: set then clear bit 7
        post(1, 1'b1, 3'd7);
        step(1'b0);
        post(2, 1'b0, 3'd7);
        step(1'b0);
        idle(3);
        @(negedge clk);
        check("t5_flags8", 32'(f8), 32'h02);

        // Out-of-range index on the 6-flag instance
        post(3, 1'b1, 3'd7);
        step(1'b0);
        @(negedge clk);
        check("t6_ready6", 32'(rdy6), 32'b1000);
        step(1'b0);
        @(negedge clk);
        check("t6_no_S6", 32'(s6), 32'd0);
        check("t6_no_R6", 32'(r6), 32'd0);
        check("t6_S8", 32'(s8), 32'h80);
        idle(3);
        @(negedge clk);
        check("t6_flags6", 32'(f6), 32'h02);
        check("t6_flags8", 32'(f8), 32'h82);
        for (int r = 0; r < 4; r++) post(r, 1'b0, 3'd6);
        step(1'b0);
        @(negedge clk);
        check("t6_ptr_wrap", 32'(rdy6), 32'b0001);
        idle(6);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 4; r++)
                if (!pv[r] && $urandom_range(0, 2) == 0)
                    post(r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            drive_cycle($urandom_range(0, 15) == 0);
        end
        for (int r = 0; r < 4; r++) pv[r] = 1'b0;
        idle(8);
        @(negedge clk); #1;
        check("final_flags8", 32'(f8), 32'(sh8));
        check("final_flags6", 32'({2'b00, f6}), 32'(sh6));
        check("grants_left", 32'(gq.size()), 32'd0);
        check("pulses8_left", 32'(pq8.size()), 32'd0);
        check("pulses6_left", 32'(pq6.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
